// File: rtl/display_scheduler.sv
// display_scheduler: selects time or rotating score bytes for a 2-digit display,
// blanking it briefly after each hit.
module display_scheduler #(
  parameter int HOLD_TICKS  = 8,
  parameter int FLASH_TICKS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        game_active,
  input  logic        game_over,
  input  logic        hit,
  input  logic [7:0]  time_bcd,
  input  logic [15:0] score_bcd,
  output logic [7:0]  score_val,
  output logic [1:0]  src,
  output logic        blank
);
  localparam int MAXT = HOLD_TICKS > FLASH_TICKS ? HOLD_TICKS : FLASH_TICKS;
  localparam int CW   = MAXT > 1 ? $clog2(MAXT) : 1;
  typedef enum logic [2:0] {IDLE, TIME, FLASH, HI, LO} state_t;
  state_t          state_q, state_d, over_st;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      score_val_q;
  logic [1:0]      src_q;
  logic            blank_q;
  logic            top_zero, flash_done, hold_done;
  assign top_zero   = score_bcd[15:8] == 8'h00;
  assign flash_done = cnt_q == CW'(FLASH_TICKS - 1);
  assign hold_done  = cnt_q == CW'(HOLD_TICKS - 1);
  // A zero top byte skips HI so leading zeros never reach the display.
  assign over_st    = game_over ? (top_zero ? LO : HI) : IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = game_active ? TIME : over_st;
      TIME: state_d = !game_active ? over_st : (hit ? FLASH : TIME);
      FLASH: begin
        if (!game_active) state_d = over_st;
        else if (hit) cnt_d = '0;
        else if (tick) begin
          state_d = flash_done ? TIME : FLASH;
          cnt_d   = flash_done ? '0 : cnt_q + 1'b1;
        end
      end
      HI, LO: begin
        if (game_active) state_d = TIME;
        else if (!game_over) state_d = IDLE;
        else if (state_q == HI && top_zero) state_d = LO;
        else if (tick) begin
          state_d = !hold_done ? state_q : ((state_q == HI || top_zero) ? LO : HI);
          cnt_d   = hold_done ? '0 : cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      score_val_q <= 8'h00;
      src_q       <= 2'b00;
      blank_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_val_q <= (state_d == TIME || state_d == FLASH) ? time_bcd :
                     state_d == HI ? score_bcd[15:8] :
                     state_d == LO ? score_bcd[7:0] : 8'h00;
      src_q       <= (state_d == TIME || state_d == FLASH) ? 2'b01 :
                     state_d == HI ? 2'b10 :
                     state_d == LO ? 2'b11 : 2'b00;
      blank_q     <= state_d == IDLE || state_d == FLASH;
    end
  end
  assign score_val = score_val_q;
  assign src       = src_q;
  assign blank     = blank_q;
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed scenarios plus random stimulus, checked each
// cycle against a phase/ticks-remaining model of the scheduler.
module tb_display_scheduler;
  localparam int HT = 8, FT = 3;
  localparam int M_IDLE = 0, M_TIME = 1, M_FLASH = 2, M_HI = 3, M_LO = 4;
  logic        clk = 0, rst = 0, tick = 0, game_active = 0, game_over = 0, hit = 0;
  logic [7:0]  time_bcd = 8'h00;
  logic [15:0] score_bcd = 16'h0000;
  logic [7:0]  score_val;
  logic [1:0]  src;
  logic        blank;
  int          n_tests = 0, n_fail = 0;
  int          mode = M_IDLE, left = 0;
  logic [7:0]  e_val = 8'h00;
  logic [1:0]  e_src = 2'b00;
  logic        e_blank = 1'b1;
  bit          started = 0, saw_hi = 0;

  display_scheduler #(.HOLD_TICKS(HT), .FLASH_TICKS(FT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .game_active(game_active),
    .game_over(game_over), .hit(hit), .time_bcd(time_bcd), .score_bcd(score_bcd),
    .score_val(score_val), .src(src), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Model tracks the displayed phase and how many ticks remain in it.
  always @(posedge clk) begin : model
    int nm, over;
    bit top0;
    top0 = score_bcd[15:8] == 8'h00;
    over = !game_over ? M_IDLE : (top0 ? M_LO : M_HI);
    nm = mode;
    if (!rst) nm = M_IDLE;
    else if (mode == M_IDLE) nm = game_active ? M_TIME : over;
    else if (mode == M_TIME || mode == M_FLASH) begin
      if (!game_active) nm = over;
      else if (hit) begin nm = M_FLASH; left = FT; end
      else if (mode == M_FLASH && tick) begin
        left--;
        if (left == 0) nm = M_TIME;
      end
    end else begin
      if (game_active) nm = M_TIME;
      else if (!game_over) nm = M_IDLE;
      else if (mode == M_HI && top0) nm = M_LO;
      else if (tick) begin
        left--;
        if (left == 0) begin
          nm = (mode == M_HI || top0) ? M_LO : M_HI;
          left = HT;
        end
      end
    end
    if (nm != mode) left = (nm == M_FLASH) ? FT : HT;
    mode = nm;
    e_val   = (nm == M_TIME || nm == M_FLASH) ? time_bcd :
              nm == M_HI ? score_bcd[15:8] : nm == M_LO ? score_bcd[7:0] : 8'h00;
    e_src   = nm == M_IDLE ? 2'd0 : (nm == M_TIME || nm == M_FLASH) ? 2'd1 : nm == M_HI ? 2'd2 : 2'd3;
    e_blank = nm == M_IDLE || nm == M_FLASH;
    started = 1;
  end

  always @(negedge clk) if (started) begin
    check("val", score_val, e_val);
    check("src", {6'd0, src}, {6'd0, e_src});
    check("blank", {7'd0, blank}, {7'd0, e_blank});
  end

  task automatic cyc(input bit t, input bit h);
    @(negedge clk);
    tick = t;
    hit = h;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(0, 0); cyc(0, 0);
    check("rst_blank", {7'd0, blank}, 8'd1);
    check("rst_src", {6'd0, src}, 8'd0);
    check("rst_val", score_val, 8'h00);
    rst = 1; game_active = 1; time_bcd = 8'h59;
    cyc(0, 0);
    check("time_src", {6'd0, src}, 8'd1);
    check("time_val", score_val, 8'h59);
    check("time_blank", {7'd0, blank}, 8'd0);
    cyc(0, 1);
    check("flash_on", {7'd0, blank}, 8'd1);
    cyc(1, 0); cyc(0, 0); cyc(1, 0);
    check("flash_2ticks", {7'd0, blank}, 8'd1);
    cyc(1, 0);
    check("flash_done", {7'd0, blank}, 8'd0);
    cyc(0, 1); cyc(1, 0); cyc(0, 1);
    cyc(1, 0); cyc(1, 0);
    check("rehit_hold", {7'd0, blank}, 8'd1);
    cyc(1, 0);
    check("rehit_done", {7'd0, blank}, 8'd0);
    cyc(0, 1); cyc(1, 0); cyc(1, 0); cyc(1, 1);
    check("tickhit_stay", {7'd0, blank}, 8'd1);
    cyc(1, 0); cyc(1, 0);
    check("tickhit_hold", {7'd0, blank}, 8'd1);
    cyc(1, 0);
    check("tickhit_done", {7'd0, blank}, 8'd0);
    game_active = 0; game_over = 1; score_bcd = 16'h0123;
    cyc(0, 0);
    check("rot_hi_src", {6'd0, src}, 8'd2);
    check("rot_hi_val", score_val, 8'h01);
    for (int i = 0; i < 7; i++) cyc(1, 0);
    check("rot_hi_held", {6'd0, src}, 8'd2);
    cyc(1, 0);
    check("rot_lo_src", {6'd0, src}, 8'd3);
    check("rot_lo_val", score_val, 8'h23);
    for (int i = 0; i < 8; i++) cyc(1, 0);
    check("rot_back_hi", {6'd0, src}, 8'd2);
    score_bcd = 16'h0042;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0);
      if (src == 2'd2) saw_hi = 1;
    end
    check("no_hi", {7'd0, saw_hi}, 8'd0);
    check("lo_val", score_val, 8'h42);
    rst = 0; cyc(0, 0);
    rst = 1; game_active = 1; game_over = 1;
    cyc(0, 0);
    check("both_time", {6'd0, src}, 8'd1);
    game_active = 0; score_bcd = 16'h0123;
    cyc(0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0);
    rst = 0; cyc(1, 0);
    check("midrot_rst_src", {6'd0, src}, 8'd0);
    check("midrot_rst_blank", {7'd0, blank}, 8'd1);
    rst = 1; cyc(0, 0);
    check("resume_hi", {6'd0, src}, 8'd2);
    for (int i = 0; i < 7; i++) cyc(1, 0);
    check("full_hold_hi", {6'd0, src}, 8'd2);
    cyc(1, 0);
    check("full_hold_lo", {6'd0, src}, 8'd3);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 60) != 0;
      if ($urandom_range(0, 19) == 0) game_active = ~game_active;
      if ($urandom_range(0, 19) == 0) game_over = ~game_over;
      if ($urandom_range(0, 3) == 0) time_bcd = 8'($urandom);
      if ($urandom_range(0, 9) == 0)
        score_bcd = {($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom), 8'($urandom)};
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
    end
    cyc(0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
